bcd_conv_scheduler: RTL and testbench
=====================================

// Module: bcd_conv_scheduler
// PURPOSE
//  Shares one bin2bcd converter core among N_REQ requesters (voltage, current, power, energy readouts).
//  Round-robin arbitration, clamping of out-of-range values, sequencing of the core's enable/done
//  handshake, and a watchdog so a hung core cannot stall the display/UART paths.
//  Sits between the measurement blocks and the bin2bcd core; the J1 peripheral path is unchanged.
// PARAMETERS
//  N_REQ    4     number of requesters (2..8)
//  DATA_W   14    binary operand width fed to the core
//  TIMEOUT  1023  max cycles in WAIT or RELEASE before abort; watchdog counter width = $clog2(TIMEOUT+1)
// PORTS
//  clk        in   1            system clock; all state on posedge clk
//  rst        in   1            asynchronous, active-low reset
//  req        in   N_REQ        level request per requester; held until its ack
//  req_data   in   N_REQ*DATA_W packed operands, slice i = [i*DATA_W +: DATA_W]; stable while req[i]=1
//  ack        out  N_REQ        one-cycle pulse to the served requester; bcd_out/ovf/err valid that cycle
//  bcd_out    out  16           {tho,hun,ten,uni} result, held until next ack
//  ovf        out  1            operand was >9999 and was clamped; qualified by ack
//  err        out  1            watchdog abort; qualified by ack
//  busy       out  1            state != IDLE
//  conv_en    out  1            to core enable
//  conv_data  out  DATA_W       to core data
//  conv_done  in   1            from core done
//  conv_bcd   in   16           from core {tho,hun,ten,uni}
// BEHAVIOUR
//  Reset (rst=0, async): state=IDLE, ack=0, bcd_out=0, ovf=0, err=0, conv_en=0, conv_data=0,
//   rr pointer=0, watchdog=0. A reset mid-conversion drops conv_en immediately; no ack is issued.
//  FSM IDLE -> WAIT -> ACK -> RELEASE -> IDLE; all outputs registered.
//  IDLE: if |req, grant g = first set bit searching from pointer upward, wrapping mod N_REQ.
//   Latch g; conv_data <= min(req_data[g], 9999); ovf_q <= (req_data[g] > 9999);
//   conv_en <= 1; watchdog <= 0; -> WAIT. When req=0, stay in IDLE and leave outputs unchanged.
//  WAIT: conv_en held 1. conv_done=1 -> bcd_out <= conv_bcd, err <= 0, ovf <= ovf_q,
//   ack[g] <= 1, conv_en <= 0, -> ACK.
//   watchdog == TIMEOUT without done -> bcd_out <= 16'h0000, err <= 1, ovf <= ovf_q, ack[g] <= 1,
//   conv_en <= 0, -> ACK. When conv_done=1 and the watchdog expire in the same cycle, done wins.
//  ACK: ack <= 0; pointer <= (g+1) mod N_REQ; watchdog <= 0; -> RELEASE.
//  RELEASE: wait for conv_done=0 (core re-armed), then -> IDLE. If watchdog reaches TIMEOUT, also
//   -> IDLE and set sticky err (cleared on the next good ack); no second ack is issued.
//  Latency: req[g] sampled in IDLE at edge k -> conv_en=1 after k; done sampled at edge d -> ack high
//   for cycle d..d+1. Minimum req-to-ack = core latency + 1; minimum back-to-back spacing = 3 + done-fall.
//  Requester drops req mid-conversion: the conversion completes and ack still pulses (requester ignores it).
//   A new req on the granted index during ACK/RELEASE waits for round-robin order.
//  Fairness: any requester held high is served within N_REQ grants.
//  conv_data never exceeds 9999, so the core's 4-digit range is never violated.
// STRUCTURE
//  bcd_ctrl_defs.vh (shared include): state encodings S_IDLE..S_RELEASE, BCD_MAX=14'd9999,
//   BCD_W=16, error-code constants reused by the display and UART formatters.
//  Sub-module rr_arbiter #(N_REQ): inputs req and pointer; outputs one-hot grant and binary index;
//   purely combinational. The FSM, clamp, and watchdog live in bcd_conv_scheduler.
// TESTING (bench uses a behavioural core model with programmable done latency and stuck-done)
//  1 Single req[1], data=14'd1234, core latency 17 -> conv_data=1234; ack[1] one cycle; bcd_out=16'h1234;
//    ovf=0; err=0.
//  2 After reset, req=4'b0101 held with data 42 and 7 -> grant order 0,2,0,2; bcd_out 16'h0042, 16'h0007, ...
//  3 req[3], data=14'd16383 -> conv_data=9999; bcd_out=16'h9999; ovf=1 with ack[3].
//  4 Core never asserts done -> ack after TIMEOUT+1 cycles in WAIT; err=1; bcd_out=0; conv_en low;
//    next good request clears err.
//  5 rst pulsed low mid-WAIT -> conv_en=0 asynchronously; no ack; busy=0; after release,
//    pending req restarts from pointer 0.
//  6 req[2] dropped during WAIT while req[0] is pending -> ack[2] still pulses; then req[0] is served;
//    conv_en is not reasserted until conv_done has fallen.

Source files
------------

// File: rtl/bcd_conv_scheduler_pkg.sv
// Shared constants for the bin2bcd converter scheduler.
// FSM encodings, BCD range limit and error codes for the formatters.
package bcd_conv_scheduler_pkg;

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_WAIT    = 2'd1;
    localparam logic [1:0] S_ACK     = 2'd2;
    localparam logic [1:0] S_RELEASE = 2'd3;

    localparam int unsigned BCD_MAX = 9999;
    localparam int          BCD_W   = 16;

    localparam logic [1:0] ERR_NONE    = 2'd0;
    localparam logic [1:0] ERR_TIMEOUT = 2'd1;
    localparam logic [1:0] ERR_CLAMP   = 2'd2;

endpackage

// File: rtl/bcd_conv_scheduler_rr_arbiter.sv
// Combinational round-robin arbiter.
// Picks the first set request at or above ptr, wrapping modulo N_REQ.
module bcd_conv_scheduler_rr_arbiter #(
    parameter  int N_REQ = 4,
    localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
    input  logic [N_REQ-1:0] req,
    input  logic [IDX_W-1:0] ptr,
    output logic [N_REQ-1:0] grant,
    output logic [IDX_W-1:0] idx
);

    // Rotating search starting at the pointer position
    always_comb begin : search
        int   j;
        logic found;
        grant = '0;
        idx   = '0;
        found = 1'b0;
        j     = 0;
        for (int k = 0; k < N_REQ; k++) begin
            j = int'(ptr) + k;
            if (j >= N_REQ) j = j - N_REQ;
            if (!found && req[j]) begin
                found    = 1'b1;
                grant[j] = 1'b1;
                idx      = IDX_W'(j);
            end
        end
    end

endmodule

// File: rtl/bcd_conv_scheduler.sv
// Shares one bin2bcd core among N_REQ requesters.
// Round-robin grant, operand clamp, handshake sequencing, watchdog.
module bcd_conv_scheduler
    import bcd_conv_scheduler_pkg::*;
#(
    parameter int N_REQ   = 4,
    parameter int DATA_W  = 14,
    parameter int TIMEOUT = 1023
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [N_REQ-1:0]        req,
    input  logic [N_REQ*DATA_W-1:0] req_data,
    output logic [N_REQ-1:0]        ack,
    output logic [BCD_W-1:0]        bcd_out,
    output logic                    ovf,
    output logic                    err,
    output logic                    busy,
    output logic                    conv_en,
    output logic [DATA_W-1:0]       conv_data,
    input  logic                    conv_done,
    input  logic [BCD_W-1:0]        conv_bcd
);

    localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int WD_W  = $clog2(TIMEOUT + 1);

    logic [1:0]        state;
    logic [IDX_W-1:0]  ptr;
    logic [IDX_W-1:0]  g_idx;
    logic [N_REQ-1:0]  g_oh;
    logic [WD_W-1:0]   wd;
    logic              ovf_q;

    logic [N_REQ-1:0]  arb_grant;
    logic [IDX_W-1:0]  arb_idx;
    logic [DATA_W-1:0] opnd;
    logic              over;
    logic              wd_exp;

    bcd_conv_scheduler_rr_arbiter #(.N_REQ(N_REQ)) u_arb (
        .req   (req),
        .ptr   (ptr),
        .grant (arb_grant),
        .idx   (arb_idx)
    );

    // Operand of the winning requester and its range check
    always_comb begin
        opnd = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (arb_idx == IDX_W'(i)) opnd = req_data[i*DATA_W +: DATA_W];
        end
        over = 32'(opnd) > BCD_MAX;
    end

    assign wd_exp = (wd == WD_W'(TIMEOUT));
    assign busy   = (state != S_IDLE);

    // Scheduler FSM with watchdog; every output is a register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= S_IDLE;
            ptr       <= '0;
            g_idx     <= '0;
            g_oh      <= '0;
            wd        <= '0;
            ovf_q     <= 1'b0;
            ack       <= '0;
            bcd_out   <= '0;
            ovf       <= 1'b0;
            err       <= 1'b0;
            conv_en   <= 1'b0;
            conv_data <= '0;
        end else begin
            unique case (state)
                S_IDLE: begin
                    if (|req) begin
                        g_idx     <= arb_idx;
                        g_oh      <= arb_grant;
                        conv_data <= over ? DATA_W'(BCD_MAX) : opnd;
                        ovf_q     <= over;
                        conv_en   <= 1'b1;
                        wd        <= '0;
                        state     <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (conv_done) begin
                        bcd_out <= conv_bcd;
                        err     <= 1'b0;
                        ovf     <= ovf_q;
                        ack     <= g_oh;
                        conv_en <= 1'b0;
                        state   <= S_ACK;
                    end else if (wd_exp) begin
                        bcd_out <= '0;
                        err     <= 1'b1;
                        ovf     <= ovf_q;
                        ack     <= g_oh;
                        conv_en <= 1'b0;
                        state   <= S_ACK;
                    end else begin
                        wd <= wd + 1'b1;
                    end
                end
                S_ACK: begin
                    ack   <= '0;
                    ptr   <= (g_idx == IDX_W'(N_REQ - 1)) ? '0 : g_idx + 1'b1;
                    wd    <= '0;
                    state <= S_RELEASE;
                end
                S_RELEASE: begin
                    // Core must drop done before the next grant
                    if (!conv_done) begin
                        state <= S_IDLE;
                    end else if (wd_exp) begin
                        err   <= 1'b1;
                        state <= S_IDLE;
                    end else begin
                        wd <= wd + 1'b1;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_bcd_conv_scheduler.sv
// Directed bench for bcd_conv_scheduler.
// Behavioural core with programmable latency, hang and stuck-done.
module tb_bcd_conv_scheduler;

    localparam int N_REQ   = 4;
    localparam int DATA_W  = 14;
    localparam int TIMEOUT = 1023;

    logic                    clk = 1'b0;
    logic                    rst = 1'b0;
    logic [N_REQ-1:0]        req = '0;
    logic [N_REQ*DATA_W-1:0] req_data = '0;
    logic [N_REQ-1:0]        ack;
    logic [15:0]             bcd_out;
    logic                    ovf;
    logic                    err;
    logic                    busy;
    logic                    conv_en;
    logic [DATA_W-1:0]       conv_data;
    logic                    conv_done;
    logic [15:0]             conv_bcd;

    int checks = 0;
    int errors = 0;
    int lat    = 17;
    bit hang   = 1'b0;
    bit stuck  = 1'b0;
    int cnt;
    int n;

    bcd_conv_scheduler #(
        .N_REQ(N_REQ), .DATA_W(DATA_W), .TIMEOUT(TIMEOUT)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .req_data  (req_data),
        .ack       (ack),
        .bcd_out   (bcd_out),
        .ovf       (ovf),
        .err       (err),
        .busy      (busy),
        .conv_en   (conv_en),
        .conv_data (conv_data),
        .conv_done (conv_done),
        .conv_bcd  (conv_bcd)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] to_bcd(input logic [DATA_W-1:0] v);
        int x;
        x = int'(v);
        return {4'(x / 1000 % 10), 4'(x / 100 % 10), 4'(x / 10 % 10), 4'(x % 10)};
    endfunction

    // Core model: done after lat enabled cycles, held while enabled
    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            conv_done <= 1'b0;
            conv_bcd  <= '0;
            cnt       <= 0;
        end else if (conv_en) begin
            if (!conv_done && !hang) begin
                if (cnt + 1 >= lat) begin
                    conv_done <= 1'b1;
                    conv_bcd  <= to_bcd(conv_data);
                end
                cnt <= cnt + 1;
            end
        end else begin
            cnt       <= 0;
            conv_done <= stuck;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
            $error("%s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_ack(input int limit, output int cyc);
        cyc = 0;
        do begin
            tick();
            cyc++;
        end while (ack == '0 && cyc < limit);
        chk("ack_seen", 32'(|ack), 32'd1);
    endtask

    task automatic wait_idle();
        int c;
        c = 0;
        while (busy && c < 2000) begin
            tick();
            c++;
        end
        chk("idle", 32'(busy), 32'd0);
    endtask

    task automatic set_data(input int i, input int v);
        req_data[i*DATA_W +: DATA_W] = DATA_W'(v);
    endtask

    initial begin
        #12;
        chk("rst_ack", 32'(ack), 32'd0);
        chk("rst_bcd", 32'(bcd_out), 32'd0);
        chk("rst_ovf", 32'(ovf), 32'd0);
        chk("rst_err", 32'(err), 32'd0);
        chk("rst_en", 32'(conv_en), 32'd0);
        chk("rst_data", 32'(conv_data), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        tick();
        rst = 1'b1;
        tick();

        // Single request, latency 17
        lat = 17;
        set_data(1, 1234);
        req = 4'b0010;
        tick();
        chk("t1_en", 32'(conv_en), 32'd1);
        chk("t1_data", 32'(conv_data), 32'd1234);
        chk("t1_busy", 32'(busy), 32'd1);
        wait_ack(100, n);
        chk("t1_lat", 32'(n), 32'd18);
        chk("t1_ack", 32'(ack), 32'h2);
        chk("t1_bcd", 32'(bcd_out), 32'h1234);
        chk("t1_ovf", 32'(ovf), 32'd0);
        chk("t1_err", 32'(err), 32'd0);
        req = 4'b0000;
        tick();
        chk("t1_pulse", 32'(ack), 32'd0);
        wait_idle();

        // Round robin between 0 and 2 after reset
        rst = 1'b0;
        tick();
        rst = 1'b1;
        lat = 3;
        set_data(0, 42);
        set_data(2, 7);
        req = 4'b0101;
        for (int i = 0; i < 4; i++) begin
            wait_ack(100, n);
            chk("t2_ack", 32'(ack), (i % 2 == 0) ? 32'h1 : 32'h4);
            chk("t2_bcd", 32'(bcd_out), (i % 2 == 0) ? 32'h0042 : 32'h0007);
        end
        req = 4'b0000;
        wait_idle();

        // Clamp of out-of-range operand
        set_data(3, 16383);
        req = 4'b1000;
        tick();
        chk("t3_data", 32'(conv_data), 32'd9999);
        wait_ack(100, n);
        chk("t3_ack", 32'(ack), 32'h8);
        chk("t3_bcd", 32'(bcd_out), 32'h9999);
        chk("t3_ovf", 32'(ovf), 32'd1);
        chk("t3_err", 32'(err), 32'd0);
        req = 4'b0000;
        wait_idle();

        // Hung core triggers watchdog abort
        hang = 1'b1;
        set_data(1, 100);
        req = 4'b0010;
        tick();
        chk("t4_en", 32'(conv_en), 32'd1);
        wait_ack(2000, n);
        chk("t4_lat", 32'(n), 32'(TIMEOUT + 1));
        chk("t4_ack", 32'(ack), 32'h2);
        chk("t4_err", 32'(err), 32'd1);
        chk("t4_bcd", 32'(bcd_out), 32'd0);
        chk("t4_en_low", 32'(conv_en), 32'd0);
        hang = 1'b0;
        req = 4'b0000;
        wait_idle();
        set_data(2, 55);
        req = 4'b0100;
        wait_ack(100, n);
        chk("t4_ack2", 32'(ack), 32'h4);
        chk("t4_err_clr", 32'(err), 32'd0);
        chk("t4_bcd2", 32'(bcd_out), 32'h0055);
        req = 4'b0000;
        wait_idle();

        // Async reset mid-WAIT, pointer returns to 0
        lat = 50;
        req = 4'b0100;
        tick();
        chk("t5_en", 32'(conv_en), 32'd1);
        repeat (5) tick();
        #2;
        rst = 1'b0;
        #1;
        chk("t5_en_rst", 32'(conv_en), 32'd0);
        chk("t5_busy", 32'(busy), 32'd0);
        chk("t5_ack", 32'(ack), 32'd0);
        req = 4'b1010;
        tick();
        tick();
        rst = 1'b1;
        lat = 4;
        wait_ack(100, n);
        chk("t5_ack2", 32'(ack), 32'h2);
        chk("t5_bcd", 32'(bcd_out), 32'h0100);
        req = 4'b0000;
        wait_idle();

        // Dropped request still acked; re-grant waits on done fall
        lat = 10;
        set_data(0, 2024);
        set_data(2, 9999);
        req = 4'b0101;
        tick();
        chk("t6_data", 32'(conv_data), 32'd9999);
        repeat (3) tick();
        req = 4'b0001;
        wait_ack(100, n);
        chk("t6_ack", 32'(ack), 32'h4);
        chk("t6_bcd", 32'(bcd_out), 32'h9999);
        chk("t6_ovf", 32'(ovf), 32'd0);
        stuck = 1'b1;
        repeat (6) tick();
        chk("t6_en_hold", 32'(conv_en), 32'd0);
        chk("t6_busy", 32'(busy), 32'd1);
        stuck = 1'b0;
        wait_ack(100, n);
        chk("t6_ack2", 32'(ack), 32'h1);
        chk("t6_bcd2", 32'(bcd_out), 32'h2024);
        chk("t6_err", 32'(err), 32'd0);
        req = 4'b0000;
        wait_idle();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
